// File: rtl/arkanoid_pkg.sv
// Shared Arkanoid sequencer types: FSM state encoding and timing constants.
// The countdown timer itself lives outside the sequencer and reloads to TIMER_RELOAD.
package arkanoid_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_MISS  = 3'd4,
      ST_LVLUP = 3'd5,
      ST_OVER  = 3'd6
   } state_e;

   localparam logic [7:0] TIMER_RELOAD = 8'd180;
   localparam int         FRAME_HZ     = 60;

   // States in which the countdown timer is allowed to run.
   function automatic logic is_delay_state(input state_e s);
      return (s == ST_SERVE) || (s == ST_MISS) || (s == ST_LVLUP) || (s == ST_OVER);
   endfunction

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: 2-FF synchronizer followed by a registered rising-edge pulse.
// The event pulse appears three clocks after the raw input rises.
module btn_edge
   import arkanoid_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic evt_o
);

   logic sync1_q, sync2_q, prev_q, evt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         evt_q   <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         evt_q   <= sync2_q & ~prev_q;
      end
   end

   assign evt_o = evt_q;

endmodule

// File: rtl/game_ctrl_fsm.sv
// Arkanoid game sequencer: state machine, lives/level counters and timer handshake.
// timer_start and brick_reload are registered so they fire in the first cycle of the entered state.
module game_ctrl_fsm
   import arkanoid_pkg::*;
#(
   parameter int LIVES_INIT = 3,
   parameter int LIVES_W    = 2,
   parameter int LEVEL_W    = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               btn_start,
   input  logic               refr_tick,
   input  logic               ball_miss,
   input  logic               bricks_clear,
   input  logic               timer_up,
   output logic               timer_start,
   output logic               timer_tick,
   output logic               play_en,
   output logic               ball_reset,
   output logic               brick_reload,
   output logic               game_over,
   output logic [LIVES_W-1:0] lives,
   output logic [LEVEL_W-1:0] level,
   output logic [2:0]         state_o
);

   state_e             state_q, state_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               timer_start_q, timer_start_d;
   logic               brick_reload_q, brick_reload_d;
   logic               over_seen_q, over_seen_d;
   logic               btn_evt;
   logic               tmr_done;

   btn_edge u_btn_start (
      .clk   (clk),
      .reset (reset),
      .btn_i (btn_start),
      .evt_o (btn_evt)
   );

   // timer_up still reflects the previous countdown during the reload cycle.
   assign tmr_done = timer_up & ~timer_start_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         lives_q        <= LIVES_W'(LIVES_INIT);
         level_q        <= '0;
         timer_start_q  <= 1'b0;
         brick_reload_q <= 1'b0;
         over_seen_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         lives_q        <= lives_d;
         level_q        <= level_d;
         timer_start_q  <= timer_start_d;
         brick_reload_q <= brick_reload_d;
         over_seen_q    <= over_seen_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      lives_d        = lives_q;
      level_d        = level_q;
      timer_start_d  = 1'b0;
      brick_reload_d = 1'b0;
      over_seen_d    = over_seen_q;
      case (state_q)
         ST_IDLE: begin
            if (btn_evt) begin
               state_d        = ST_SERVE;
               lives_d        = LIVES_W'(LIVES_INIT);
               level_d        = '0;
               brick_reload_d = 1'b1;
               timer_start_d  = 1'b1;
            end
         end
         ST_SERVE: begin
            if (tmr_done) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (bricks_clear) begin
               state_d       = ST_LVLUP;
               timer_start_d = 1'b1;
            end else if (ball_miss) begin
               timer_start_d = 1'b1;
               if (lives_q > LIVES_W'(1)) begin
                  state_d = ST_MISS;
                  lives_d = lives_q - LIVES_W'(1);
               end else begin
                  state_d     = ST_OVER;
                  lives_d     = '0;
                  over_seen_d = 1'b0;
               end
            end else if (btn_evt) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (btn_evt) state_d = ST_PLAY;
         end
         ST_MISS: begin
            if (tmr_done) begin
               state_d       = ST_SERVE;
               timer_start_d = 1'b1;
            end
         end
         ST_LVLUP: begin
            if (tmr_done) begin
               state_d        = ST_SERVE;
               level_d        = level_q + LEVEL_W'(1);
               brick_reload_d = 1'b1;
               timer_start_d  = 1'b1;
            end
         end
         ST_OVER: begin
            // The start button only leaves the game-over screen once the countdown has expired.
            if (over_seen_q && btn_evt) begin
               state_d     = ST_IDLE;
               over_seen_d = 1'b0;
            end else if (tmr_done) begin
               over_seen_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      play_en    = 1'b0;
      ball_reset = 1'b1;
      game_over  = 1'b0;
      case (state_q)
         ST_PLAY: begin
            play_en    = 1'b1;
            ball_reset = 1'b0;
         end
         ST_PAUSE: ball_reset = 1'b0;
         ST_OVER:  game_over  = 1'b1;
         default: ;
      endcase
   end

   assign timer_tick   = refr_tick & is_delay_state(state_q);
   assign timer_start  = timer_start_q;
   assign brick_reload = brick_reload_q;
   assign lives        = lives_q;
   assign level        = level_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm with a behavioural 180-tick countdown timer model.
module tb_game_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset, btn_start, refr_tick, ball_miss, bricks_clear, timer_up;
   logic       timer_start, timer_tick, play_en, ball_reset, brick_reload, game_over;
   logic [1:0] lives;
   logic [2:0] level;
   logic [2:0] state_o;
   logic [7:0] tcnt_q;
   int         n_cmp = 0;
   int         n_err = 0;
   int         n;

   always #5 clk = ~clk;

   game_ctrl_fsm #(.LIVES_INIT(3), .LIVES_W(2), .LEVEL_W(3)) dut (
      .clk(clk), .reset(reset), .btn_start(btn_start), .refr_tick(refr_tick),
      .ball_miss(ball_miss), .bricks_clear(bricks_clear), .timer_up(timer_up),
      .timer_start(timer_start), .timer_tick(timer_tick), .play_en(play_en),
      .ball_reset(ball_reset), .brick_reload(brick_reload), .game_over(game_over),
      .lives(lives), .level(level), .state_o(state_o)
   );

   // Countdown timer model: reload on timer_start, count down on timer_tick, up at zero.
   always_ff @(posedge clk) begin
      if (reset)                           tcnt_q <= 8'd0;
      else if (timer_start)                tcnt_q <= 8'd180;
      else if (timer_tick && tcnt_q != 0)  tcnt_q <= tcnt_q - 8'd1;
   end
   assign timer_up = (tcnt_q == 8'd0);

   task automatic step;
      @(posedge clk); #1;
   endtask

   task automatic press;
      btn_start = 1'b1; step(); step();
      btn_start = 1'b0; step(); step();
   endtask

   task automatic pulse_miss;
      ball_miss = 1'b1; step(); ball_miss = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] s, output int cnt);
      cnt = 0;
      while (state_o !== s && cnt < 400) begin
         step();
         cnt++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; btn_start = 1'b0; ball_miss = 1'b0; bricks_clear = 1'b0; refr_tick = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL rst_state got=%0d want=0", state_o); end
      n_cmp++; if (lives !== 2'd3) begin n_err++; $display("FAIL rst_lives got=%0d want=3", lives); end
      n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level got=%0d want=0", level); end
      n_cmp++; if ({timer_start, brick_reload, play_en, game_over, timer_tick} !== 5'b0) begin
         n_err++; $display("FAIL rst_outs got=%b want=00000", {timer_start, brick_reload, play_en, game_over, timer_tick}); end
      n_cmp++; if (ball_reset !== 1'b1) begin n_err++; $display("FAIL rst_ball_reset got=%b want=1", ball_reset); end
   endtask

   task automatic test_start;
      press();
      n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL start_state got=%0d want=1", state_o); end
      n_cmp++; if ({timer_start, brick_reload} !== 2'b11) begin n_err++; $display("FAIL start_pulses got=%b want=11", {timer_start, brick_reload}); end
      n_cmp++; if (timer_tick !== 1'b1) begin n_err++; $display("FAIL start_tick got=%b want=1", timer_tick); end
      step();
      n_cmp++; if ({timer_start, brick_reload} !== 2'b00) begin n_err++; $display("FAIL start_pulse_len got=%b want=00", {timer_start, brick_reload}); end
      n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL start_stale_up got=%0d want=1", state_o); end
   endtask

   task automatic test_serve;
      wait_state(3'd2, n);
      n_cmp++; if (n !== 181) begin n_err++; $display("FAIL serve_cycles got=%0d want=181", n); end
      n_cmp++; if ({play_en, timer_tick, ball_reset} !== 3'b100) begin
         n_err++; $display("FAIL play_outs got=%b want=100", {play_en, timer_tick, ball_reset}); end
   endtask

   task automatic test_miss;
      for (int k = 0; k < 2; k++) begin
         pulse_miss();
         n_cmp++; if (state_o !== 3'd4) begin n_err++; $display("FAIL miss%0d_state got=%0d want=4", k, state_o); end
         n_cmp++; if (lives !== 2'(2 - k)) begin n_err++; $display("FAIL miss%0d_lives got=%0d want=%0d", k, lives, 2 - k); end
         n_cmp++; if ({timer_start, play_en} !== 2'b10) begin n_err++; $display("FAIL miss%0d_outs got=%b want=10", k, {timer_start, play_en}); end
         wait_state(3'd1, n);
         n_cmp++; if (n !== 182) begin n_err++; $display("FAIL miss%0d_cycles got=%0d want=182", k, n); end
         n_cmp++; if ({timer_start, brick_reload} !== 2'b10) begin n_err++; $display("FAIL miss%0d_serve got=%b want=10", k, {timer_start, brick_reload}); end
         wait_state(3'd2, n);
         n_cmp++; if (n !== 182) begin n_err++; $display("FAIL miss%0d_play got=%0d want=182", k, n); end
      end
      pulse_miss();
      n_cmp++; if (state_o !== 3'd6) begin n_err++; $display("FAIL last_state got=%0d want=6", state_o); end
      n_cmp++; if (lives !== 2'd0) begin n_err++; $display("FAIL last_lives got=%0d want=0", lives); end
      n_cmp++; if ({game_over, timer_start} !== 2'b11) begin n_err++; $display("FAIL last_outs got=%b want=11", {game_over, timer_start}); end
   endtask

   task automatic test_over;
      press();
      n_cmp++; if (state_o !== 3'd6) begin n_err++; $display("FAIL over_early_btn got=%0d want=6", state_o); end
      repeat (185) step();
      n_cmp++; if (state_o !== 3'd6) begin n_err++; $display("FAIL over_hold got=%0d want=6", state_o); end
      press();
      n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL over_exit got=%0d want=0", state_o); end
      n_cmp++; if ({game_over, lives} !== 3'b000) begin n_err++; $display("FAIL idle_outs got=%b want=000", {game_over, lives}); end
   endtask

   task automatic test_level;
      press();
      n_cmp++; if ({state_o, lives, level, brick_reload} !== {3'd1, 2'd3, 3'd0, 1'b1}) begin
         n_err++; $display("FAIL newgame got=%b want=%b", {state_o, lives, level, brick_reload}, {3'd1, 2'd3, 3'd0, 1'b1}); end
      wait_state(3'd2, n);
      n_cmp++; if (n !== 182) begin n_err++; $display("FAIL newgame_play got=%0d want=182", n); end
      bricks_clear = 1'b1; ball_miss = 1'b1; step(); bricks_clear = 1'b0; ball_miss = 1'b0;
      n_cmp++; if ({state_o, lives, timer_start} !== {3'd5, 2'd3, 1'b1}) begin
         n_err++; $display("FAIL lvlup got=%b want=%b", {state_o, lives, timer_start}, {3'd5, 2'd3, 1'b1}); end
      wait_state(3'd1, n);
      n_cmp++; if (n !== 182) begin n_err++; $display("FAIL lvlup_cycles got=%0d want=182", n); end
      n_cmp++; if ({level, brick_reload, timer_start} !== {3'd1, 2'b11}) begin
         n_err++; $display("FAIL lvlup_serve got=%b want=%b", {level, brick_reload, timer_start}, {3'd1, 2'b11}); end
      wait_state(3'd2, n);
      n_cmp++; if (n !== 182) begin n_err++; $display("FAIL lvlup_play got=%0d want=182", n); end
   endtask

   task automatic test_pause;
      press();
      n_cmp++; if (state_o !== 3'd3) begin n_err++; $display("FAIL pause_state got=%0d want=3", state_o); end
      n_cmp++; if ({play_en, ball_reset, timer_tick} !== 3'b000) begin
         n_err++; $display("FAIL pause_outs got=%b want=000", {play_en, ball_reset, timer_tick}); end
      bricks_clear = 1'b1; pulse_miss(); bricks_clear = 1'b0;
      n_cmp++; if ({state_o, lives} !== {3'd3, 2'd3}) begin n_err++; $display("FAIL pause_ignore got=%b want=%b", {state_o, lives}, {3'd3, 2'd3}); end
      press();
      n_cmp++; if ({state_o, play_en, timer_start} !== {3'd2, 2'b10}) begin
         n_err++; $display("FAIL resume got=%b want=%b", {state_o, play_en, timer_start}, {3'd2, 2'b10}); end
   endtask

   task automatic test_reset_mid;
      pulse_miss();
      n_cmp++; if ({state_o, lives} !== {3'd4, 2'd2}) begin n_err++; $display("FAIL mid_miss got=%b want=%b", {state_o, lives}, {3'd4, 2'd2}); end
      repeat (10) step();
      reset = 1'b1; step(); reset = 1'b0;
      n_cmp++; if ({state_o, lives, level} !== {3'd0, 2'd3, 3'd0}) begin
         n_err++; $display("FAIL mid_reset got=%b want=%b", {state_o, lives, level}, {3'd0, 2'd3, 3'd0}); end
      n_cmp++; if ({timer_start, brick_reload} !== 2'b00) begin n_err++; $display("FAIL mid_pulse got=%b want=00", {timer_start, brick_reload}); end
      step();
      n_cmp++; if ({state_o, timer_start} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL mid_after got=%b want=0000", {state_o, timer_start}); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_serve();
      test_miss();
      test_over();
      test_level();
      test_pause();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
